dmem_sram_ctrl: RTL and testbench
=================================

Name: dmem_sram_ctrl

Overview:
Data-side memory access controller that sits between the CPU M stage and the SRAM-like data bus, ahead of the AXI bridge.
- Converts a single-cycle M-stage load/store into a req / addr_ok / data_ok transaction.
- Raises d_stall toward the hazard unit until the access completes.
- Holds load data until the global pipeline stall releases.
- Drains and discards an in-flight access when an exception flush arrives.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
mem_en  in  1  M-stage access valid
mem_wen  in  4  byte write enables; 0 = load
mem_size  in  2  load size (0 byte, 1 half, 2 word)
mem_addr  in  ADDR_W  byte address
mem_wdata  in  DATA_W  store data, byte-lane aligned
mem_rdata  out  DATA_W  load data (valid in DONE)
d_stall  out  1  data-side stall request to hazard unit
longest_stall  in  1  global pipeline stall (i_stall | d_stall | div stall)
flush  in  1  exception flush of M stage
data_req  out  1  bus request
data_wr  out  1  1 = write
data_size  out  2  transfer size
data_addr  out  ADDR_W  bus address
data_wdata  out  DATA_W  bus write data
data_addr_ok  in  1  request accepted
data_data_ok  in  1  response/data valid
data_rdata  in  DATA_W  bus read data

Behaviour:
- Reset:
  - state = IDLE, discard = 0, rdata_r = 0.
  - All outputs 0.
  - Reset mid-transaction abandons it; the bus side is reset together with this block.
- States: IDLE, REQ, WAIT, DONE (2-bit register).
- Request issue:
  - data_req = (IDLE & mem_en & ~flush) | REQ.
  - Address, size and write data are driven combinationally from the inputs in IDLE.
  - In REQ and WAIT they come from registers captured at IDLE exit.
- data_wr = |wen.
- Store size from wen:
  - 1111 -> 2
  - 0011 or 1100 -> 1
  - one-hot -> 0
  - Any other nonzero pattern -> 2 (illegal, not generated upstream).
- Load size = mem_size.
- data_addr = mem_addr with the low 2 bits forced to 0 when size = 2.
- Transitions:
  - IDLE -> WAIT when req and addr_ok in the same cycle.
  - IDLE -> REQ when req and ~addr_ok.
  - REQ -> WAIT on addr_ok. req stays high and the payload stays stable until then; a request is never withdrawn.
  - WAIT -> DONE on data_ok with discard = 0; rdata_r <= data_rdata. Stores also go to DONE, rdata_r unchanged.
  - WAIT -> IDLE on data_ok with discard = 1; discard cleared.
  - DONE -> IDLE when ~longest_stall (pipeline advances past the access).
  - DONE with longest_stall = 1: hold, no new request.
- Timing:
  - Only one outstanding transaction.
  - data_ok is ignored outside WAIT.
  - data_ok in the same cycle as addr_ok is not accepted; the bus guarantees it arrives at least 1 cycle later.
- d_stall = (IDLE & mem_en & ~flush) | REQ | WAIT. DONE gives d_stall = 0.
- Minimum load latency: addr_ok in cycle 0, data_ok in cycle 1, DONE in cycle 2. d_stall is high in cycles 0-1.
- mem_rdata = rdata_r (registered; stable throughout DONE).
- Flush:
  - flush in IDLE: no request issued.
  - flush in REQ or WAIT: discard <= 1. The transaction completes on the bus and its data is dropped. d_stall stays high until drained.
  - flush in DONE: immediate -> IDLE.
  - flush and data_ok in the same WAIT cycle: -> IDLE, data dropped.
- A new access in IDLE requires mem_en; back-to-back accesses pass through DONE -> IDLE, so there is at least 1 idle cycle between requests.

Test Plan:
- Word load at 0x80001004: addr_ok in cycle 0, data_ok in cycle 2 with rdata 0x12345678 -> data_req high for 1 cycle, d_stall high in cycles 0-2, DONE in cycle 3, mem_rdata = 0x12345678, IDLE on the first cycle with longest_stall = 0.
- Byte store wen = 0100 at 0x80000002, addr_ok delayed 3 cycles -> data_req held with addr, wdata and data_size = 0 constant for 4 cycles, data_wr = 1, DONE after data_ok.
- Load completes while longest_stall = 1 for 5 more cycles (i_stall) -> remains in DONE, d_stall = 0, mem_rdata stable, no second data_req.
- flush asserted in WAIT, then data_ok with 0xDEADBEEF -> returns to IDLE, mem_rdata keeps its previous value, d_stall high until data_ok.
- flush with mem_en in IDLE -> data_req and d_stall stay 0.
- Half store wen = 1100 followed by word load -> data_size 1 then 2, one req per access, no overlap of outstanding transactions.

Source files
------------

// File: rtl/dmem_sram_ctrl.sv
// Data-side memory access controller: turns a single-cycle M-stage load/store
// into a req / addr_ok / data_ok transaction on the SRAM-like data bus, stalls
// the pipeline until the access completes and holds load data in DONE until
// the global stall releases. A flush drains and discards an in-flight access.
module dmem_sram_ctrl #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    // M-stage side
    input  logic              mem_en,
    input  logic [3:0]        mem_wen,
    input  logic [1:0]        mem_size,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              d_stall,
    input  logic              longest_stall,
    input  logic              flush,
    // SRAM-like data bus
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_discard;
    logic [DATA_W-1:0] r_rdata;
    logic              r_wr;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    logic              w_idle;
    logic              w_issue;
    logic              w_in_wr;
    logic [1:0]        w_in_size;
    logic [ADDR_W-1:0] w_in_addr;

    assign w_idle  = (r_state == S_IDLE);
    assign w_issue = w_idle & mem_en & ~flush;
    assign w_in_wr = |mem_wen;

    // Transfer size: stores derive it from the byte enables, loads use mem_size
    always_comb begin
        w_in_size = mem_size;
        if (w_in_wr) begin
            case (mem_wen)
                4'b1111:                               w_in_size = 2'd2;
                4'b0011, 4'b1100:                      w_in_size = 2'd1;
                4'b0001, 4'b0010, 4'b0100, 4'b1000:    w_in_size = 2'd0;
                default:                               w_in_size = 2'd2;
            endcase
        end
    end

    // Word transfers are issued word-aligned
    always_comb begin
        w_in_addr = mem_addr;
        if (w_in_size == 2'd2) begin
            w_in_addr[1:0] = 2'b00;
        end
    end

    // Bus payload: live inputs while idle, captured copy once the request is out
    always_comb begin
        if (w_idle) begin
            data_wr    = w_in_wr;
            data_size  = w_in_size;
            data_addr  = w_in_addr;
            data_wdata = mem_wdata;
        end else begin
            data_wr    = r_wr;
            data_size  = r_size;
            data_addr  = r_addr;
            data_wdata = r_wdata;
        end
    end

    assign data_req  = w_issue | (r_state == S_REQ);
    assign d_stall   = w_issue | (r_state == S_REQ) | (r_state == S_WAIT);
    assign mem_rdata = r_rdata;

    // Transaction FSM with payload capture, discard tracking and load data hold
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_discard <= 1'b0;
            r_rdata   <= '0;
            r_wr      <= 1'b0;
            r_size    <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_issue) begin
                        r_wr      <= w_in_wr;
                        r_size    <= w_in_size;
                        r_addr    <= w_in_addr;
                        r_wdata   <= mem_wdata;
                        r_discard <= 1'b0;
                        r_state   <= data_addr_ok ? S_WAIT : S_REQ;
                    end
                end
                S_REQ: begin
                    // The request stays up until accepted; a flush only marks it for discard
                    if (flush) begin
                        r_discard <= 1'b1;
                    end
                    if (data_addr_ok) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (data_data_ok) begin
                        if (r_discard || flush) begin
                            r_discard <= 1'b0;
                            r_state   <= S_IDLE;
                        end else begin
                            if (!r_wr) begin
                                r_rdata <= data_rdata;
                            end
                            r_state <= S_DONE;
                        end
                    end else if (flush) begin
                        r_discard <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (flush || !longest_stall) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_sram_ctrl.sv
// Directed bench for dmem_sram_ctrl: the bench plays both the M stage and the
// data bus; expected requests and load data go into queues and are popped when
// the controller presents them.
module tb_dmem_sram_ctrl;

    logic        clk;
    logic        resetn;
    logic        mem_en;
    logic [3:0]  mem_wen;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        d_stall;
    logic        longest_stall;
    logic        flush;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    req_t        q_req[$];
    logic [31:0] q_rd[$];
    int          n_vec;
    int          n_err;
    int          n_push;
    int          n_hs;

    dmem_sram_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .mem_en        (mem_en),
        .mem_wen       (mem_wen),
        .mem_size      (mem_size),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .d_stall       (d_stall),
        .longest_stall (longest_stall),
        .flush         (flush),
        .data_req      (data_req),
        .data_wr       (data_wr),
        .data_size     (data_size),
        .data_addr     (data_addr),
        .data_wdata    (data_wdata),
        .data_addr_ok  (data_addr_ok),
        .data_data_ok  (data_data_ok),
        .data_rdata    (data_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count accepted bus requests
    always @(negedge clk) begin
        if (resetn && data_req && data_addr_ok) n_hs++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic drv(input logic en, input logic [3:0] wen, input logic [1:0] sz,
                       input logic [31:0] addr, input logic [31:0] wd);
        mem_en    = en;
        mem_wen   = wen;
        mem_size  = sz;
        mem_addr  = addr;
        mem_wdata = wd;
    endtask

    task automatic push_req(input logic wr, input logic [1:0] sz,
                            input logic [31:0] addr, input logic [31:0] wd);
        req_t r;
        r.wr    = wr;
        r.size  = sz;
        r.addr  = addr;
        r.wdata = wd;
        q_req.push_back(r);
        n_push++;
    endtask

    // Compare the bus request against the scoreboard head; pop when accepted
    task automatic chk_req(input string tag, input bit pop);
        req_t r;
        if (q_req.size() == 0) begin
            chk({tag, "_queue"}, 32'(q_req.size()), 32'd1);
        end else begin
            r = q_req[0];
            chk({tag, "_req"},   32'(data_req),  32'd1);
            chk({tag, "_wr"},    32'(data_wr),   32'(r.wr));
            chk({tag, "_size"},  32'(data_size), 32'(r.size));
            chk({tag, "_addr"},  data_addr,      r.addr);
            chk({tag, "_wdata"}, data_wdata,     r.wdata);
            if (pop) void'(q_req.pop_front());
        end
    endtask

    task automatic chk_rd(input string tag, input bit pop);
        if (q_rd.size() == 0) begin
            chk({tag, "_queue"}, 32'(q_rd.size()), 32'd1);
        end else begin
            chk(tag, mem_rdata, q_rd[0]);
            if (pop) void'(q_rd.pop_front());
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0; n_push = 0; n_hs = 0;
        resetn = 1'b0;
        drv(1'b0, 4'b0000, 2'd0, 32'h0, 32'h0);
        longest_stall = 1'b0;
        flush         = 1'b0;
        data_addr_ok  = 1'b0;
        data_data_ok  = 1'b0;
        data_rdata    = 32'h0;

        // Reset state
        repeat (2) @(posedge clk);
        smp();
        chk("rst_req",   32'(data_req),   32'd0);
        chk("rst_stall", 32'(d_stall),    32'd0);
        chk("rst_rdata", mem_rdata,       32'd0);
        chk("rst_wr",    32'(data_wr),    32'd0);
        chk("rst_size",  32'(data_size),  32'd0);
        chk("rst_addr",  data_addr,       32'd0);
        chk("rst_wdata", data_wdata,      32'd0);
        cyc(); resetn = 1'b1;
        smp(); chk("idle_stall", 32'(d_stall), 32'd0);

        // Word load, addr_ok in cycle 0, data_ok in cycle 2
        cyc(); drv(1'b1, 4'b0000, 2'd2, 32'h8000_1004, 32'h0);
        longest_stall = 1'b1; data_addr_ok = 1'b1;
        push_req(1'b0, 2'd2, 32'h8000_1004, 32'h0);
        smp(); chk_req("t1_c0", 1'b1); chk("t1_c0_stall", 32'(d_stall), 32'd1);
        cyc(); data_addr_ok = 1'b0;
        smp(); chk("t1_c1_req", 32'(data_req), 32'd0); chk("t1_c1_stall", 32'(d_stall), 32'd1);
        cyc(); data_data_ok = 1'b1; data_rdata = 32'h1234_5678; q_rd.push_back(32'h1234_5678);
        smp(); chk("t1_c2_req", 32'(data_req), 32'd0); chk("t1_c2_stall", 32'(d_stall), 32'd1);
        cyc(); data_data_ok = 1'b0; longest_stall = 1'b0;
        smp(); chk("t1_done_stall", 32'(d_stall), 32'd0); chk("t1_done_req", 32'(data_req), 32'd0);
        chk_rd("t1_rdata", 1'b1);

        // Byte store, addr_ok after 3 cycles; M-stage inputs garbled meanwhile
        cyc(); drv(1'b1, 4'b0100, 2'd0, 32'h8000_0002, 32'h00AB_0000);
        longest_stall = 1'b1;
        push_req(1'b1, 2'd0, 32'h8000_0002, 32'h00AB_0000);
        smp(); chk_req("t2_c0", 1'b0); chk("t2_c0_stall", 32'(d_stall), 32'd1);
        for (int i = 0; i < 2; i++) begin
            cyc(); drv(1'b1, 4'b1111, 2'd3, 32'hFFFF_FFFF, 32'h0);
            smp(); chk_req("t2_hold", 1'b0);
        end
        cyc(); data_addr_ok = 1'b1;
        smp(); chk_req("t2_c3", 1'b1);
        cyc(); data_addr_ok = 1'b0;
        smp(); chk("t2_wait_req", 32'(data_req), 32'd0); chk("t2_wait_stall", 32'(d_stall), 32'd1);
        cyc(); data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D;
        smp(); chk("t2_dok_stall", 32'(d_stall), 32'd1);
        cyc(); data_data_ok = 1'b0; longest_stall = 1'b0;
        smp(); chk("t2_done_stall", 32'(d_stall), 32'd0);
        chk("t2_rdata_kept", mem_rdata, 32'h1234_5678);

        // Half load finishing under a 5-cycle global stall
        cyc(); drv(1'b1, 4'b0000, 2'd1, 32'h8000_0012, 32'h0);
        longest_stall = 1'b1; data_addr_ok = 1'b1;
        push_req(1'b0, 2'd1, 32'h8000_0012, 32'h0);
        smp(); chk_req("t3_c0", 1'b1);
        cyc(); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h5A5A_1234;
        q_rd.push_back(32'h5A5A_1234);
        smp(); chk("t3_c1_stall", 32'(d_stall), 32'd1);
        for (int i = 0; i < 5; i++) begin
            cyc(); data_data_ok = 1'b0;
            smp(); chk("t3_hold_stall", 32'(d_stall), 32'd0);
            chk("t3_hold_req", 32'(data_req), 32'd0);
            chk_rd("t3_hold_rdata", 1'b0);
        end
        cyc(); longest_stall = 1'b0;
        smp(); chk("t3_rel_stall", 32'(d_stall), 32'd0); chk_rd("t3_rel_rdata", 1'b1);

        // Flush while waiting for data: result dropped
        cyc(); drv(1'b1, 4'b0000, 2'd2, 32'h8000_0020, 32'h0);
        longest_stall = 1'b1; data_addr_ok = 1'b1;
        push_req(1'b0, 2'd2, 32'h8000_0020, 32'h0);
        smp(); chk_req("t4_c0", 1'b1);
        cyc(); data_addr_ok = 1'b0; flush = 1'b1;
        smp(); chk("t4_flush_stall", 32'(d_stall), 32'd1); chk("t4_flush_req", 32'(data_req), 32'd0);
        cyc(); flush = 1'b0; drv(1'b0, 4'b0000, 2'd0, 32'h0, 32'h0);
        smp(); chk("t4_drain_stall", 32'(d_stall), 32'd1);
        cyc(); data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
        smp(); chk("t4_dok_stall", 32'(d_stall), 32'd1);
        cyc(); data_data_ok = 1'b0; longest_stall = 1'b0;
        smp(); chk("t4_idle_stall", 32'(d_stall), 32'd0); chk("t4_idle_req", 32'(data_req), 32'd0);
        chk("t4_rdata_kept", mem_rdata, 32'h5A5A_1234);

        // Flush with mem_en in IDLE: nothing issued
        cyc(); drv(1'b1, 4'b0000, 2'd2, 32'h8000_0030, 32'h0); flush = 1'b1;
        smp(); chk("t5_req", 32'(data_req), 32'd0); chk("t5_stall", 32'(d_stall), 32'd0);

        // Half store followed by a word load at an unaligned address
        cyc(); flush = 1'b0; drv(1'b1, 4'b1100, 2'd0, 32'h8000_0042, 32'hBEEF_0000);
        longest_stall = 1'b1; data_addr_ok = 1'b1;
        push_req(1'b1, 2'd1, 32'h8000_0042, 32'hBEEF_0000);
        smp(); chk_req("t6_st", 1'b1);
        cyc(); data_addr_ok = 1'b0;
        smp(); chk("t6_st_wait_req", 32'(data_req), 32'd0); chk("t6_st_wait_stall", 32'(d_stall), 32'd1);
        cyc(); data_data_ok = 1'b1; data_rdata = 32'h7777_7777;
        smp(); chk("t6_st_dok_req", 32'(data_req), 32'd0);
        cyc(); data_data_ok = 1'b0; longest_stall = 1'b0;
        smp(); chk("t6_st_done_stall", 32'(d_stall), 32'd0); chk("t6_st_done_req", 32'(data_req), 32'd0);
        chk("t6_st_rdata_kept", mem_rdata, 32'h5A5A_1234);
        cyc(); drv(1'b1, 4'b0000, 2'd2, 32'h8000_0047, 32'h0); longest_stall = 1'b1;
        push_req(1'b0, 2'd2, 32'h8000_0044, 32'h0);
        smp(); chk_req("t6_ld_c0", 1'b0);
        cyc(); data_addr_ok = 1'b1;
        smp(); chk_req("t6_ld_c1", 1'b1);
        cyc(); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h0BAD_CAFE;
        q_rd.push_back(32'h0BAD_CAFE);
        smp(); chk("t6_ld_dok_stall", 32'(d_stall), 32'd1);
        cyc(); data_data_ok = 1'b0; longest_stall = 1'b0;
        smp(); chk("t6_ld_done_stall", 32'(d_stall), 32'd0); chk_rd("t6_ld_rdata", 1'b1);

        // Flush in DONE releases to IDLE despite a global stall
        cyc(); drv(1'b1, 4'b0000, 2'd2, 32'h8000_0100, 32'h0);
        longest_stall = 1'b1; data_addr_ok = 1'b1;
        push_req(1'b0, 2'd2, 32'h8000_0100, 32'h0);
        smp(); chk_req("t7_a", 1'b1);
        cyc(); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h1111_2222;
        q_rd.push_back(32'h1111_2222);
        smp(); chk("t7_a_stall", 32'(d_stall), 32'd1);
        cyc(); data_data_ok = 1'b0; flush = 1'b1;
        smp(); chk("t7_done_stall", 32'(d_stall), 32'd0); chk_rd("t7_a_rdata", 1'b1);
        cyc(); flush = 1'b0; drv(1'b1, 4'b0000, 2'd2, 32'h8000_0104, 32'h0); data_addr_ok = 1'b1;
        push_req(1'b0, 2'd2, 32'h8000_0104, 32'h0);
        smp(); chk_req("t7_b", 1'b1);
        cyc(); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h3333_4444;
        q_rd.push_back(32'h3333_4444);
        smp(); chk("t7_b_stall", 32'(d_stall), 32'd1);
        cyc(); data_data_ok = 1'b0; longest_stall = 1'b0;
        smp(); chk_rd("t7_b_rdata", 1'b1);
        cyc(); drv(1'b0, 4'b0000, 2'd0, 32'h0, 32'h0);
        smp(); chk("end_req", 32'(data_req), 32'd0); chk("end_stall", 32'(d_stall), 32'd0);

        // One accepted request per access, nothing left in the scoreboard
        chk("handshakes", 32'(n_hs), 32'(n_push));
        chk("req_q_empty", 32'(q_req.size()), 32'd0);
        chk("rd_q_empty", 32'(q_rd.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
